// File: rtl/axil_csr_pkg.sv
// Shared types and helpers for the AXI4-Lite CSR responder: response codes,
// register-map sizing defaults and word-index classification.
package axil_csr_pkg;

    typedef enum logic [1:0] {
        AXIL_OKAY   = 2'b00,
        AXIL_SLVERR = 2'b10
    } axil_resp_e;

    typedef enum logic [1:0] {
        REG_RW      = 2'b00,
        REG_RO      = 2'b01,
        REG_INVALID = 2'b10
    } reg_class_e;

    localparam int unsigned AXIL_ADDR_W   = 10;
    localparam int unsigned AXIL_DATA_W   = 32;
    localparam int unsigned AXIL_IDX_W    = AXIL_ADDR_W - 2;
    localparam int unsigned AXIL_NUM_RW   = 8;
    localparam int unsigned AXIL_NUM_RO   = 4;
    localparam int unsigned AXIL_NUM_REGS = AXIL_NUM_RW + AXIL_NUM_RO;

    // RW registers sit first in the map, RO registers directly after them.
    function automatic reg_class_e classify_index(
        input int unsigned idx,
        input int unsigned num_rw,
        input int unsigned num_ro
    );
        reg_class_e cls;
        if (idx < num_rw) begin
            cls = REG_RW;
        end else if (idx < (num_rw + num_ro)) begin
            cls = REG_RO;
        end else begin
            cls = REG_INVALID;
        end
        return cls;
    endfunction

endpackage

// File: rtl/axil_csr_responder_hold.sv
// One-entry holding register (valid + payload) used to park an accepted AW
// or W beat until the write can commit.
module axil_hold_reg #(
    parameter int unsigned width_p = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               i_enq,
    input  logic [width_p-1:0] i_data,
    input  logic               i_deq,
    output logic               o_full,
    output logic [width_p-1:0] o_data
);

    logic               r_full;
    logic [width_p-1:0] r_data;

    // Entry state: dequeue wins, enqueue only happens while empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_deq) begin
            r_full <= 1'b0;
        end else if (i_enq) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/axil_csr_responder.sv
// AXI4-Lite responder exposing RW control and RO status registers; bad
// accesses complete with SLVERR so the bus can never hang.
module axil_csr_responder
    import axil_csr_pkg::*;
#(
    parameter int unsigned addr_width_p = AXIL_ADDR_W,
    parameter int unsigned data_width_p = AXIL_DATA_W,
    parameter int unsigned num_rw_p     = AXIL_NUM_RW,
    parameter int unsigned num_ro_p     = AXIL_NUM_RO
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [addr_width_p-1:0]          s_axil_awaddr_i,
    input  logic [2:0]                       s_axil_awprot_i,
    input  logic                             s_axil_awvalid_i,
    output logic                             s_axil_awready_o,
    input  logic [data_width_p-1:0]          s_axil_wdata_i,
    input  logic [data_width_p/8-1:0]        s_axil_wstrb_i,
    input  logic                             s_axil_wvalid_i,
    output logic                             s_axil_wready_o,
    output logic [1:0]                       s_axil_bresp_o,
    output logic                             s_axil_bvalid_o,
    input  logic                             s_axil_bready_i,
    input  logic [addr_width_p-1:0]          s_axil_araddr_i,
    input  logic [2:0]                       s_axil_arprot_i,
    input  logic                             s_axil_arvalid_i,
    output logic                             s_axil_arready_o,
    output logic [data_width_p-1:0]          s_axil_rdata_o,
    output logic [1:0]                       s_axil_rresp_o,
    output logic                             s_axil_rvalid_o,
    input  logic                             s_axil_rready_i,
    output logic [num_rw_p*data_width_p-1:0] csr_o,
    output logic [num_rw_p-1:0]              csr_w_v_o,
    input  logic [num_ro_p*data_width_p-1:0] status_i
);

    localparam int unsigned IDX_W  = addr_width_p - 2;
    localparam int unsigned STRB_W = data_width_p / 8;
    localparam int unsigned W_W    = data_width_p + STRB_W;

    logic [data_width_p-1:0] r_csr [num_rw_p];
    logic [num_rw_p-1:0]     r_csr_w_v;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [data_width_p-1:0] r_rdata;

    logic                    w_aw_full;
    logic                    w_w_full;
    logic [IDX_W-1:0]        w_aw_idx;
    logic [W_W-1:0]          w_w_payload;
    logic [data_width_p-1:0] w_wr_data;
    logic [STRB_W-1:0]       w_wr_strb;
    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_ar_fire;
    logic                    w_commit;
    reg_class_e              w_wr_cls;
    logic [IDX_W-1:0]        w_ar_idx;
    logic [data_width_p-1:0] w_rd_data;
    axil_resp_e              w_rd_resp;
    logic                    w_unused_bits;

    assign w_unused_bits = ^{s_axil_awprot_i, s_axil_arprot_i,
                             s_axil_awaddr_i[1:0], s_axil_araddr_i[1:0]};

    // Readies are forced low during reset even though the entries are empty.
    assign s_axil_awready_o = aresetn & ~w_aw_full;
    assign s_axil_wready_o  = aresetn & ~w_w_full;
    assign s_axil_arready_o = aresetn & (~r_rvalid | s_axil_rready_i);

    assign w_aw_fire = s_axil_awvalid_i & s_axil_awready_o;
    assign w_w_fire  = s_axil_wvalid_i & s_axil_wready_o;
    assign w_ar_fire = s_axil_arvalid_i & s_axil_arready_o;
    assign w_commit  = w_aw_full & w_w_full & (~r_bvalid | s_axil_bready_i);

    axil_hold_reg #(
        .width_p (IDX_W)
    ) u_aw_hold (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_enq   (w_aw_fire),
        .i_data  (s_axil_awaddr_i[addr_width_p-1:2]),
        .i_deq   (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_idx)
    );

    axil_hold_reg #(
        .width_p (W_W)
    ) u_w_hold (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_enq   (w_w_fire),
        .i_data  ({s_axil_wstrb_i, s_axil_wdata_i}),
        .i_deq   (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_payload)
    );

    assign w_wr_data = w_w_payload[data_width_p-1:0];
    assign w_wr_strb = w_w_payload[W_W-1:data_width_p];
    assign w_wr_cls  = classify_index(32'(w_aw_idx), num_rw_p, num_ro_p);
    assign w_ar_idx  = s_axil_araddr_i[addr_width_p-1:2];

    // Write commit: byte-lane update, one-cycle pulse and B response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < int'(num_rw_p); k++) begin
                r_csr[k] <= '0;
            end
            r_csr_w_v <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_csr_w_v <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_wr_cls == REG_RW) ? AXIL_OKAY : AXIL_SLVERR;
                if (w_wr_cls == REG_RW) begin
                    for (int k = 0; k < int'(num_rw_p); k++) begin
                        if (w_aw_idx == IDX_W'(k)) begin
                            r_csr_w_v[k] <= 1'b1;
                            for (int b = 0; b < int'(STRB_W); b++) begin
                                if (w_wr_strb[b]) begin
                                    r_csr[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end else if (s_axil_bready_i) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read mux; RW registers are read before this edge's write lands.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = AXIL_SLVERR;
        case (classify_index(32'(w_ar_idx), num_rw_p, num_ro_p))
            REG_RW: begin
                w_rd_resp = AXIL_OKAY;
                for (int k = 0; k < int'(num_rw_p); k++) begin
                    w_rd_data = (w_ar_idx == IDX_W'(k)) ? r_csr[k] : w_rd_data;
                end
            end
            REG_RO: begin
                w_rd_resp = AXIL_OKAY;
                for (int j = 0; j < int'(num_ro_p); j++) begin
                    w_rd_data = (w_ar_idx == IDX_W'(int'(num_rw_p) + j))
                              ? status_i[j*data_width_p +: data_width_p]
                              : w_rd_data;
                end
            end
            default: begin
                w_rd_data = '0;
                w_rd_resp = AXIL_SLVERR;
            end
        endcase
    end

    // Read response register: loads on AR accept, holds until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else if (w_ar_fire) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (s_axil_rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

    for (genvar k = 0; k < int'(num_rw_p); k++) begin : g_csr_out
        assign csr_o[k*data_width_p +: data_width_p] = r_csr[k];
    end

    assign csr_w_v_o       = r_csr_w_v;
    assign s_axil_bvalid_o = r_bvalid;
    assign s_axil_bresp_o  = r_bresp;
    assign s_axil_rvalid_o = r_rvalid;
    assign s_axil_rresp_o  = r_rresp;
    assign s_axil_rdata_o  = r_rdata;

endmodule

// File: tb/tb_axil_csr_responder.sv
// Directed plus randomized bench for axil_csr_responder, checked against a
// simple array model of the register map.
module tb_axil_csr_responder;

    localparam int NUM_RW = 8;
    localparam int NUM_RO = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [9:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [9:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] csr;
    logic [7:0]   csr_w_v;
    logic [127:0] status;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_csr [NUM_RW];

    axil_csr_responder dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awprot_i  (awprot),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arprot_i  (arprot),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .csr_o            (csr),
        .csr_w_v_o        (csr_w_v),
        .status_i         (status)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        for (int k = 0; k < NUM_RW; k++) v[k*32 +: 32] = model_csr[k];
        return v;
    endfunction

    // Expected read result straight from the register map rules.
    task automatic model_read(input logic [9:0] addr, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(addr[9:2]);
        if (idx < NUM_RW) begin
            d = model_csr[idx]; r = 2'b00;
        end else if (idx < NUM_RW + NUM_RO) begin
            d = status[(idx-NUM_RW)*32 +: 32]; r = 2'b00;
        end else begin
            d = 32'h0; r = 2'b10;
        end
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int idx;
        int cyc;
        logic [1:0] exp_resp;
        logic [7:0] exp_pulse;
        bit aw_done, w_done, aw_hs, w_hs;
        idx = int'(addr[9:2]);
        exp_pulse = 8'h00;
        if (idx < NUM_RW) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model_csr[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_resp = 2'b00;
            exp_pulse[idx] = 1'b1;
        end else begin
            exp_resp = 2'b10;
        end
        awaddr = addr; wdata = data; wstrb = strb;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            #1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done = 1'b1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
        chk("bvalid_before_commit", bvalid, 1'b0);
        @(posedge aclk); #1;
        chk("bvalid_after_commit", bvalid, 1'b1);
        chk("bresp", bresp, exp_resp);
        chk("pulse", csr_w_v, exp_pulse);
        chk("csr_after_write", csr, model_vec());
        for (int i = 0; i < b_dly; i++) begin
            @(posedge aclk); #1;
            chk("bvalid_hold", {bvalid, bresp}, {1'b1, exp_resp});
            chk("pulse_cleared", csr_w_v, 8'h00);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk("bvalid_dropped", bvalid, 1'b0);
        chk("pulse_cleared", csr_w_v, 8'h00);
    endtask

    task automatic do_read(input logic [9:0] addr, input int r_dly);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        model_read(addr, exp_d, exp_r);
        araddr = addr; arvalid = 1'b1;
        #1;
        chk("arready_idle", arready, 1'b1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        chk("read_resp", {rvalid, rresp, rdata}, {1'b1, exp_r, exp_d});
        for (int i = 0; i < r_dly; i++) begin
            @(posedge aclk); #1;
            chk("read_hold", {rvalid, rresp, rdata}, {1'b1, exp_r, exp_d});
            chk("arready_hold", arready, 1'b0);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        chk("rvalid_dropped", rvalid, 1'b0);
    endtask

    initial begin
        logic [9:0]  b2b_addr [3];
        logic [31:0] old_val;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        status = '0;
        for (int k = 0; k < NUM_RW; k++) model_csr[k] = 32'h0;

        #3;
        chk("reset_readies", {awready, wready, arready}, 3'b000);
        chk("reset_valids", {bvalid, rvalid, bresp, rresp}, 6'b0);
        chk("reset_csr", csr, 256'h0);
        chk("reset_pulse_rdata", {csr_w_v, rdata}, 40'h0);
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1;
        #1;
        chk("readies_after_reset", {awready, wready, arready}, 3'b111);

        // AW and W together to register 1.
        do_write(10'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        // W leads AW by three cycles, single byte lane.
        do_write(10'h000, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(10'h000, 32'h000000AA, 4'h1, 3, 0, 0);
        chk("reg0_partial", csr[31:0], 32'h112233AA);
        // AW leads W, upper lanes only, slow bready.
        do_write(10'h01F, 32'h55667788, 4'hC, 0, 2, 3);
        // Zero strobe: OKAY, pulse, no data change.
        do_write(10'h00C, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
        // RO and out-of-map targets.
        do_write(10'h020, 32'h12345678, 4'hF, 0, 0, 0);
        do_write(10'h3FC, 32'h12345678, 4'hF, 1, 0, 0);
        do_read(10'h3FC, 0);
        status[31:0] = 32'hCAFEF00D;
        do_read(10'h020, 5);
        do_read(10'h02E, 1);
        do_read(10'h005, 0);

        // Back-to-back reads with rready tied high.
        b2b_addr[0] = 10'h000; b2b_addr[1] = 10'h004; b2b_addr[2] = 10'h008;
        rready = 1'b1;
        araddr = b2b_addr[0]; arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_read(b2b_addr[i], exp_d, exp_r);
            @(posedge aclk); #1;
            chk("b2b_read", {rvalid, rresp, rdata}, {1'b1, exp_r, exp_d});
            chk("b2b_arready", arready, 1'b1);
            if (i < 2) araddr = b2b_addr[i+1];
            else arvalid = 1'b0;
        end
        @(posedge aclk); #1;
        rready = 1'b0;
        chk("b2b_drain", rvalid, 1'b0);

        // Read accept and write commit to register 2 on the same edge.
        do_write(10'h008, 32'h0BADF00D, 4'hF, 0, 0, 0);
        awaddr = 10'h008; wdata = 32'h600DCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        old_val = model_csr[2];
        model_csr[2] = 32'h600DCAFE;
        araddr = 10'h008; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        chk("same_edge_read_old", {rvalid, rdata}, {1'b1, old_val});
        chk("same_edge_bvalid", {bvalid, bresp}, 3'b100);
        chk("same_edge_csr", csr, model_vec());
        rready = 1'b1; bready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0; bready = 1'b0;
        chk("same_edge_drain", {rvalid, bvalid}, 2'b00);

        // Reset while a write response is pending.
        awaddr = 10'h00C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge aclk); #1;
        chk("pending_bvalid", bvalid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("midreset_bvalid", bvalid, 1'b0);
        chk("midreset_csr", csr, 256'h0);
        chk("midreset_readies", {awready, wready, arready}, 3'b000);
        for (int k = 0; k < NUM_RW; k++) model_csr[k] = 32'h0;
        @(posedge aclk); #1;
        chk("midreset_pulse", {csr_w_v, rvalid}, 9'h0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        do_write(10'h00C, 32'h00000005, 4'hF, 0, 0, 0);
        do_read(10'h00C, 0);

        // Randomized mix of reads and writes against the model.
        for (int n = 0; n < 80; n++) begin
            logic [9:0] a;
            if ($urandom_range(0, 3) != 0) a = 10'($urandom_range(0, 47));
            else a = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) == 0) status = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end
        chk("final_csr", csr, model_vec());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_csr_responder.md
Name: axil_csr_responder

Overview:
Synthesizable AXI4-Lite responder that terminates the PS-side s00_axi control port inside the PL. It exposes a bank of read/write control registers and read-only status registers to host software and to the cosim DPI AXI-Lite master. RW registers drive fabric control signals and issue a one-cycle pulse on each committed write. Out-of-map or illegal accesses complete with SLVERR and never hang the bus.

Parameters:
addr_width_p, 10, AXI-Lite address width in bits; byte addressed, word index = addr[addr_width_p-1:2]
data_width_p, 32, AXI-Lite data width; fixed at 32 in this revision
num_rw_p, 8, number of RW registers at word indices 0..num_rw_p-1
num_ro_p, 4, number of RO registers at word indices num_rw_p..num_rw_p+num_ro_p-1

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
s_axil_awaddr_i  in  addr_width_p  write address
s_axil_awprot_i  in  3  ignored
s_axil_awvalid_i / s_axil_awready_o  in/out  1  AW handshake
s_axil_wdata_i  in  data_width_p  write data
s_axil_wstrb_i  in  data_width_p/8  byte-lane enables
s_axil_wvalid_i / s_axil_wready_o  in/out  1  W handshake
s_axil_bresp_o  out  2  write response
s_axil_bvalid_o / s_axil_bready_i  out/in  1  B handshake
s_axil_araddr_i  in  addr_width_p  read address
s_axil_arprot_i  in  3  ignored
s_axil_arvalid_i / s_axil_arready_o  in/out  1  AR handshake
s_axil_rdata_o  out  data_width_p  read data
s_axil_rresp_o  out  2  read response
s_axil_rvalid_o / s_axil_rready_i  out/in  1  R handshake
csr_o  out  num_rw_p*data_width_p  RW register contents; register k is at bits [k*32 +: 32]
csr_w_v_o  out  num_rw_p  one-hot pulse on the commit cycle of a write to register k
status_i  in  num_ro_p*data_width_p  RO register sources; sampled when a read is accepted

Behaviour:
- Reset: all csr regs 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0, csr_w_v_o 0, holding registers empty. All ready outputs are 0 while aresetn is low.
- Write path: AW and W are accepted independently, each into its own one-entry holding register.
  - awready_o = ~aw_full; wready_o = ~w_full.
  - AW and W may arrive in either order, or in the same cycle.
- Write commit fires on the edge where aw_full & w_full & (~bvalid | bready). On that edge:
  - Byte lanes with wstrb=1 update the addressed RW register.
  - csr_w_v_o[k] is high during the cycle after the commit edge, for exactly one cycle (csr_o is already updated in that cycle).
  - bvalid=1; both holding registers clear.
- Write latency: AW+W accepted at edge N -> bvalid high after edge N+1. Sustained throughput is 1 write per 2 cycles. bvalid and bresp hold stable until bready.
- bresp values:
  - 2'b00 OKAY for an RW index.
  - 2'b10 SLVERR for an RO index or an index >= num_rw_p+num_ro_p; no state change and no pulse.
  - wstrb=0 to a valid RW index: OKAY, no data change, pulse still issued.
- Read path: arready_o = ~rvalid | rready (full throughput).
  - On AR accept, rdata/rresp are registered and rvalid=1 on the next cycle.
  - RW index: csr value. RO index: status_i slice. Out of map: rdata=0, SLVERR.
  - rdata and rresp hold stable until rready.
- Same-edge read accept and write commit to the same register: read returns the pre-write value.
- Address low 2 bits are ignored (unaligned addresses are treated as aligned).
- Reset asserted mid-transaction: all pending AW/W/B/R state is discarded immediately; there is no response for in-flight transactions.

Decomposition:
- Package axil_csr_pkg:
  - axil_resp_e enum (OKAY=2'b00, SLVERR=2'b10).
  - Localparams for word-index width and total register count.
  - A function classifying an index as rw/ro/invalid.
- Sub-module axil_hold_reg: one-entry valid+data holding register with an async active-low reset and enq/deq ports. It is instantiated twice: AW (addr) and W (data+strb).

Test Plan:
- AW+W same cycle to 0x004, wdata 0xDEADBEEF, wstrb 0xF -> bvalid after 2 edges with OKAY; csr_o[63:32]=0xDEADBEEF; csr_w_v_o=0x02 for one cycle.
- W first, AW 3 cycles later, to 0x000, wdata 0x000000AA, wstrb 0x1 over an initial value of 0x11223344 -> reg0=0x112233AA; bresp OKAY.
- Write to RO index 8 (0x020) and read 0x3FC -> both return SLVERR; csr_o unchanged; rdata=0; no pulse.
- status_i slice 0 = 0xCAFEF00D; read 0x020 with rready held low 5 cycles -> rvalid and rdata=0xCAFEF00D stable throughout; arready_o=0 during the hold.
- Back-to-back reads 0x000, 0x004, 0x008 with rready tied high -> one rvalid per cycle, in order, all OKAY.
- Assert aresetn low while bvalid is pending after a write of 0x5 to reg3 -> bvalid=0, csr_o all 0, readies 0 during reset; after release, a new write completes normally.
